mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the CPU's single memory port between instruction fetch (IF) and data memory access (DM: load/store/push/pop) in the pipelined core. A 3-state FSM grants one requester at a time, drives a multi-cycle ready-handshake memory, returns read data, and produces per-side stall signals. Branch flushes discard in-flight fetch data. A bounded-streak counter stops DM from starving IF.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 16, memory data width
MAX_DM_STREAK, 4, max consecutive DM grants while IF waits; must be >= 1

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_if_req  in  1  fetch request; level, held until o_if_valid or flush
i_if_addr  in  ADDR_W  fetch address
i_flush_if  in  1  branch/ret flush from hazard unit; kills in-flight fetch
i_dm_req  in  1  data request; level, held until o_dm_valid
i_dm_we  in  1  1 = store, 0 = load
i_dm_addr  in  ADDR_W  data address
i_dm_wdata  in  DATA_W  store data
o_if_valid  out  1  one-cycle pulse: fetch complete, o_if_rdata valid
o_if_rdata  out  DATA_W  fetched word
o_if_stall  out  1  stall fetch stage
o_dm_valid  out  1  one-cycle pulse: data access complete
o_dm_rdata  out  DATA_W  load data (don't-care on store)
o_dm_stall  out  1  stall D/EM stage
o_mem_req  out  1  memory request, held until i_mem_ready
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_ready  in  1  one-cycle completion pulse from memory
i_mem_rdata  in  DATA_W  read data, valid with i_mem_ready

Behaviour:
- Reset (async, any state): state IDLE, streak 0, discard 0; all registered outputs 0. A reset mid-transaction drops o_mem_req immediately; the memory must abandon it.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration at the clock edge:
  - Grant DM if i_dm_req and (!i_if_req or streak < MAX_DM_STREAK).
  - Otherwise grant IF if i_if_req.
  - Otherwise stay IDLE.
- On grant: register o_mem_addr/we/wdata from the winner (we = 0 for IF) and set o_mem_req = 1. The request is visible in the cycle after arbitration. The memory-side signals stay stable until i_mem_ready.
- BUSY_x, on the i_mem_ready cycle:
  - o_x_valid = 1 combinationally; o_x_rdata = i_mem_rdata.
  - Next edge: o_mem_req = 0, state -> IDLE.
  - No back-to-back grant: at least one IDLE cycle between transactions. Minimum round trip = 2 cycles plus memory latency.
- i_mem_ready while IDLE: ignored.
- Stalls are combinational:
  - o_if_stall = i_if_req & !o_if_valid.
  - o_dm_stall = i_dm_req & !o_dm_valid.
- Flush:
  - i_flush_if in BUSY_IF (including the ready cycle) sets discard. The transaction still completes on the port, but o_if_valid is suppressed. discard clears on return to IDLE.
  - Flush in IDLE or BUSY_DM has no effect.
  - A flush in the IDLE cycle does not cancel an IF grant made that cycle; the requester supplies the new address afterwards.
- Streak counter:
  - +1 on each DM grant made while i_if_req = 1, saturating at MAX_DM_STREAK.
  - Cleared on any IF grant, and on any IDLE cycle with i_if_req = 0.
- Simultaneous requests with streak < MAX: DM wins (older instruction first).
- Widths: no arithmetic on address/data; the streak counter is $clog2(MAX_DM_STREAK+1) bits.

Decomposition:
- Shared include file holds state encodings (ARB_IDLE = 2'd0, ARB_BUSY_IF = 2'd1, ARB_BUSY_DM = 2'd2) and the default widths, for reuse by the hazard unit and memory model.
- One natural sub-module, arb_streak_counter: saturating counter with inc/clr inputs and an at_max output.

Test Plan:
- Reset: assert i_rst mid-BUSY_DM -> o_mem_req = 0 immediately; state IDLE, no valid pulse after release.
- Lone fetch, memory latency 3: i_if_req @ addr 0x10 -> o_mem_req from cycle 1; o_if_valid with rdata 0xABCD in cycle 4; o_if_stall high cycles 0–3.
- Contention: IF and DM requested together with streak 0 -> DM granted first (o_mem_addr = DM addr, we = i_dm_we); IF granted in the IDLE cycle after DM completes.
- Starvation: DM re-requests continuously, IF held, MAX_DM_STREAK = 4 -> exactly 4 DM grants, then an IF grant, then streak resets to 0.
- Flush: i_flush_if during BUSY_IF at latency 5 -> memory handshake completes, o_if_valid stays 0, next IDLE accepts a new fetch at addr 0x40.
- Store: i_dm_we = 1, addr 0x200, wdata 0x1234 -> o_mem_we = 1 with matching addr/data held until i_mem_ready; o_dm_valid pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the memory port arbiter.
// Reused by the hazard unit and the memory model.
package mem_port_arbiter_pkg;

   localparam int ARB_ADDR_W     = 32;
   localparam int ARB_DATA_W     = 16;
   localparam int ARB_MAX_STREAK = 4;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arb_state_e;

   function automatic int streak_w(input int max_streak);
      return $clog2(max_streak + 1);
   endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of back-to-back DM grants while IF waits.
// Clear wins over increment.
module arb_streak_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX = ARB_MAX_STREAK,
   parameter int W   = streak_w(MAX)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_max
);

   logic [W-1:0] count;

   assign o_at_max = (count == W'(MAX));

   // count DM grants, hold at MAX, drop to zero on clear
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count <= '0;
      end else if (i_clr) begin
         count <= '0;
      end else if (i_inc && !o_at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ready-handshake memory port between fetch and data access.
// DM wins ties until its streak limit; flushed fetch data is dropped.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W        = ARB_ADDR_W,
   parameter int DATA_W        = ARB_DATA_W,
   parameter int MAX_DM_STREAK = ARB_MAX_STREAK
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_flush_if,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic              o_if_valid,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_stall,
   output logic              o_dm_valid,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_dm_stall,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ready,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   arb_state_e state;
   logic       discard;
   logic       idle;
   logic       at_max;
   logic       grant_dm;
   logic       grant_if;
   logic       streak_inc;
   logic       streak_clr;

   assign idle     = (state == ARB_IDLE);
   assign grant_dm = idle & i_dm_req & (!i_if_req | !at_max);
   assign grant_if = idle & i_if_req & !grant_dm;

   assign streak_inc = grant_dm & i_if_req;
   assign streak_clr = grant_if | (idle & !i_if_req);

   arb_streak_counter #(
      .MAX (MAX_DM_STREAK)
   ) u_streak (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_inc    (streak_inc),
      .i_clr    (streak_clr),
      .o_at_max (at_max)
   );

   // completion is reported in the ready cycle itself
   assign o_if_valid = (state == ARB_BUSY_IF) & i_mem_ready
                     & !discard & !i_flush_if;
   assign o_dm_valid = (state == ARB_BUSY_DM) & i_mem_ready;
   assign o_if_rdata = i_mem_rdata;
   assign o_dm_rdata = i_mem_rdata;

   assign o_if_stall = i_if_req & !o_if_valid;
   assign o_dm_stall = i_dm_req & !o_dm_valid;

   // grant FSM; memory-side outputs latched at grant, held until ready
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ARB_IDLE;
         discard     <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               discard <= 1'b0;
               if (grant_dm) begin
                  state       <= ARB_BUSY_DM;
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= i_dm_we;
                  o_mem_addr  <= i_dm_addr;
                  o_mem_wdata <= i_dm_wdata;
               end else if (grant_if) begin
                  state       <= ARB_BUSY_IF;
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= 1'b0;
                  o_mem_addr  <= i_if_addr;
                  o_mem_wdata <= '0;
               end
            end
            ARB_BUSY_IF: begin
               if (i_mem_ready) begin
                  state     <= ARB_IDLE;
                  o_mem_req <= 1'b0;
                  discard   <= 1'b0;
               end else if (i_flush_if) begin
                  discard <= 1'b1;
               end
            end
            ARB_BUSY_DM: begin
               if (i_mem_ready) begin
                  state     <= ARB_IDLE;
                  o_mem_req <= 1'b0;
               end
            end
            default: begin
               state     <= ARB_IDLE;
               o_mem_req <= 1'b0;
               discard   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory
// model and read-data scoreboards for both requesters.
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        i_flush_if;
   logic        i_dm_req;
   logic        i_dm_we;
   logic [31:0] i_dm_addr;
   logic [15:0] i_dm_wdata;
   logic        o_if_valid;
   logic [15:0] o_if_rdata;
   logic        o_if_stall;
   logic        o_dm_valid;
   logic [15:0] o_dm_rdata;
   logic        o_dm_stall;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [15:0] o_mem_wdata;
   logic        i_mem_ready;
   logic [15:0] i_mem_rdata;

   mem_port_arbiter dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .i_flush_if  (i_flush_if),
      .i_dm_req    (i_dm_req),
      .i_dm_we     (i_dm_we),
      .i_dm_addr   (i_dm_addr),
      .i_dm_wdata  (i_dm_wdata),
      .o_if_valid  (o_if_valid),
      .o_if_rdata  (o_if_rdata),
      .o_if_stall  (o_if_stall),
      .o_dm_valid  (o_dm_valid),
      .o_dm_rdata  (o_dm_rdata),
      .o_dm_stall  (o_dm_stall),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ready (i_mem_ready),
      .i_mem_rdata (i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          chk;
      logic [15:0] data;
   } exp_t;

   exp_t        if_q[$];
   exp_t        dm_q[$];
   logic [31:0] grant_q[$];
   logic [15:0] mem [logic [31:0]];

   int          total = 0;
   int          bad = 0;
   int          lat = 3;
   int          mcnt = 0;
   int          nif = 0;
   int          ndm = 0;
   int          mark;
   bit          prev_req = 0;
   bit          saw_if;
   bit          saw_dm;
   bit          if_hold = 0;
   bit          dm_hold = 0;
   logic [31:0] g_addr;
   logic        g_we;
   logic [15:0] g_wd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: memory model + grant monitor after the edge,
   // scoreboard at the falling edge
   task automatic tick();
      exp_t e;
      saw_if = 0;
      saw_dm = 0;
      @(posedge i_clk);
      #1;
      if (!o_mem_req) begin
         mcnt = 0;
         i_mem_ready = 0;
         i_mem_rdata = '0;
      end else begin
         mcnt++;
         if (mcnt == lat + 1) begin
            i_mem_ready = 1;
            i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : 16'h0;
            if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
         end else begin
            i_mem_ready = 0;
            i_mem_rdata = '0;
         end
      end
      if (o_mem_req && !prev_req) begin
         grant_q.push_back(o_mem_addr);
         g_addr = o_mem_addr;
         g_we = o_mem_we;
         g_wd = o_mem_wdata;
      end else if (o_mem_req) begin
         chk("addr_hold", o_mem_addr, g_addr);
         chk("we_hold", {31'd0, o_mem_we}, {31'd0, g_we});
         chk("wdata_hold", {16'd0, o_mem_wdata}, {16'd0, g_wd});
      end
      prev_req = o_mem_req;
      @(negedge i_clk);
      if (o_if_valid) begin
         saw_if = 1;
         nif++;
         chk("if_valid_expected", {31'd0, if_q.size() > 0}, 32'd1);
         if (if_q.size() > 0) begin
            e = if_q.pop_front();
            if (e.chk) chk("if_rdata", {16'd0, o_if_rdata}, {16'd0, e.data});
         end
         if (!if_hold) i_if_req = 0;
      end
      if (o_dm_valid) begin
         saw_dm = 1;
         ndm++;
         chk("dm_valid_expected", {31'd0, dm_q.size() > 0}, 32'd1);
         if (dm_q.size() > 0) begin
            e = dm_q.pop_front();
            if (e.chk) chk("dm_rdata", {16'd0, o_dm_rdata}, {16'd0, e.data});
         end
         if (!dm_hold) i_dm_req = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1;
      i_if_req = 0;
      i_if_addr = '0;
      i_flush_if = 0;
      i_dm_req = 0;
      i_dm_we = 0;
      i_dm_addr = '0;
      i_dm_wdata = '0;
      i_mem_ready = 0;
      i_mem_rdata = '0;
      mem[32'h10]  = 16'hABCD;
      mem[32'h20]  = 16'h2020;
      mem[32'h300] = 16'h3030;
      mem[32'h400] = 16'h1111;
      mem[32'h50]  = 16'h2222;
      mem[32'h30]  = 16'h3333;
      mem[32'h40]  = 16'h4444;

      // reset state
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
      chk("rst_mem_addr", o_mem_addr, 32'd0);
      chk("rst_if_valid", {31'd0, o_if_valid}, 32'd0);
      chk("rst_dm_valid", {31'd0, o_dm_valid}, 32'd0);
      i_rst = 0;
      tick();

      // lone fetch, latency 3
      lat = 3;
      i_if_req = 1;
      i_if_addr = 32'h10;
      if_q.push_back('{1, 16'hABCD});
      #1;
      chk("fetch_c0_stall", {31'd0, o_if_stall}, 32'd1);
      chk("fetch_c0_req", {31'd0, o_mem_req}, 32'd0);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("fetch_req", {31'd0, o_mem_req}, 32'd1);
         chk("fetch_stall", {31'd0, o_if_stall}, 32'd1);
         chk("fetch_early_valid", {31'd0, saw_if}, 32'd0);
      end
      chk("fetch_addr", o_mem_addr, 32'h10);
      chk("fetch_we", {31'd0, o_mem_we}, 32'd0);
      tick();
      chk("fetch_c4_valid", {31'd0, saw_if}, 32'd1);
      tick();
      chk("fetch_c5_req", {31'd0, o_mem_req}, 32'd0);

      // contention: DM first, IF after one IDLE cycle
      lat = 1;
      i_dm_req = 1;
      i_dm_we = 0;
      i_dm_addr = 32'h300;
      dm_q.push_back('{1, 16'h3030});
      i_if_req = 1;
      i_if_addr = 32'h20;
      if_q.push_back('{1, 16'h2020});
      tick();
      chk("cont_req", {31'd0, o_mem_req}, 32'd1);
      chk("cont_first_addr", o_mem_addr, 32'h300);
      chk("cont_first_we", {31'd0, o_mem_we}, 32'd0);
      tick();
      chk("cont_dm_done", {31'd0, saw_dm}, 32'd1);
      tick();
      chk("cont_idle_gap", {31'd0, o_mem_req}, 32'd0);
      tick();
      chk("cont_if_req", {31'd0, o_mem_req}, 32'd1);
      chk("cont_if_addr", o_mem_addr, 32'h20);
      tick();
      chk("cont_if_done", {31'd0, saw_if}, 32'd1);
      tick();

      // starvation guard: D x4, I, then streak restarts
      grant_q.delete();
      dm_hold = 1;
      if_hold = 1;
      i_dm_addr = 32'h400;
      i_if_addr = 32'h50;
      for (int k = 0; k < 8; k++) dm_q.push_back('{1, 16'h1111});
      for (int k = 0; k < 2; k++) if_q.push_back('{1, 16'h2222});
      i_dm_req = 1;
      i_if_req = 1;
      for (int t = 0; t < 200 && grant_q.size() < 10; t++) tick();
      chk("starve_grants", {31'd0, grant_q.size() >= 10}, 32'd1);
      dm_hold = 0;
      if_hold = 0;
      i_dm_req = 0;
      for (int k = 0; k < 10 && k < grant_q.size(); k++)
         chk($sformatf("starve_grant%0d", k), grant_q[k],
             (k == 4 || k == 9) ? 32'h50 : 32'h400);
      for (int t = 0; t < 20 && (o_mem_req || if_q.size() > 0); t++) tick();
      chk("starve_drain", if_q.size() + dm_q.size(), 32'd0);
      tick();

      // flush during fetch, latency 5
      lat = 5;
      grant_q.delete();
      i_if_req = 1;
      i_if_addr = 32'h30;
      tick();
      tick();
      tick();
      i_flush_if = 1;
      i_if_addr = 32'h40;
      tick();
      i_flush_if = 0;
      mark = nif;
      for (int t = 0; t < 30 && grant_q.size() < 2; t++) tick();
      chk("flush_regrant", {31'd0, grant_q.size() == 2}, 32'd1);
      chk("flush_no_valid", nif, mark);
      if (grant_q.size() == 2) chk("flush_new_addr", grant_q[1], 32'h40);
      if_q.push_back('{1, 16'h4444});
      for (int t = 0; t < 20 && if_q.size() > 0; t++) tick();
      chk("flush_new_fetch", nif, mark + 1);
      tick();

      // store, latency 2
      lat = 2;
      i_dm_req = 1;
      i_dm_we = 1;
      i_dm_addr = 32'h200;
      i_dm_wdata = 16'h1234;
      dm_q.push_back('{0, 16'h0});
      mark = ndm;
      tick();
      chk("st_req", {31'd0, o_mem_req}, 32'd1);
      chk("st_we", {31'd0, o_mem_we}, 32'd1);
      chk("st_addr", o_mem_addr, 32'h200);
      chk("st_wdata", {16'd0, o_mem_wdata}, 32'h1234);
      for (int t = 0; t < 20 && o_mem_req; t++) tick();
      tick();
      tick();
      chk("st_one_pulse", ndm, mark + 1);
      chk("st_mem", {16'd0, mem[32'h200]}, 32'h1234);
      i_dm_we = 0;

      // reset in the middle of a DM transaction
      lat = 5;
      i_dm_req = 1;
      i_dm_addr = 32'h400;
      tick();
      chk("rst_mid_busy", {31'd0, o_mem_req}, 32'd1);
      tick();
      i_rst = 1;
      i_dm_req = 0;
      #1;
      chk("rst_mid_req_drop", {31'd0, o_mem_req}, 32'd0);
      tick();
      i_rst = 0;
      mark = ndm;
      for (int t = 0; t < 8; t++) tick();
      chk("rst_no_valid", ndm, mark);
      chk("rst_idle_req", {31'd0, o_mem_req}, 32'd0);

      chk("final_if_q", if_q.size(), 32'd0);
      chk("final_dm_q", dm_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
